// File: rtl/pipe_ctrl_if.sv
// Stage-side stall/exception inputs and control outputs of the pipeline controller.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stallreq_from_id;
  logic             stallreq_from_ex;
  logic             stallreq_from_mem;
  logic [31:0]      excepttype_i;
  logic [31:0]      cp0_epc_i;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: raises requests and exceptions, consumes the control outputs.
  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, busy, stall_cnt
  );

  // Controller side.
  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, busy, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: merges stage stall requests into the
// per-stage stall vector, sequences exception/ERET redirection (freeze, flush, recover)
// and keeps a saturating count of PC-stall cycles.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   ctrl_io
);

  typedef enum logic [1:0] {StIdle, StFreeze, StFlush, StRecover} state_e;

  localparam logic [3:0] RecoverInit = 4'(RECOVER_CYC);

  state_e           state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [5:0]       req_stall;
  logic [5:0]       stall;
  logic             flush;

  // Stall pattern from stage requests; the deepest requesting stage wins.
  always_comb begin
    req_stall = 6'b000000;
    if (ctrl_io.stallreq_from_mem) begin
      req_stall = 6'b011111;
    end else if (ctrl_io.stallreq_from_ex) begin
      req_stall = 6'b001111;
    end else if (ctrl_io.stallreq_from_id) begin
      req_stall = 6'b000111;
    end
  end

  // Next-state, redirect target latch, recovery countdown and stall vector.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rcnt_d   = rcnt_q;
    stall    = 6'b000000;
    flush    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_io.excepttype_i != 32'h0) begin
          // Exception overrides every request and freezes the whole pipe this cycle.
          stall    = 6'b111111;
          state_d  = StFreeze;
          target_d = (ctrl_io.excepttype_i == ERET_CODE) ? ctrl_io.cp0_epc_i : EXC_VECTOR;
        end else begin
          stall = req_stall;
        end
      end
      StFreeze: begin
        stall   = 6'b111111;
        state_d = StFlush;
      end
      StFlush: begin
        flush   = 1'b1;
        state_d = StRecover;
        rcnt_d  = RecoverInit;
      end
      StRecover: begin
        // Exceptions are masked here; only stage requests drive the stall vector.
        stall = req_stall;
        if (rcnt_q <= 4'd1) begin
          state_d = StIdle;
          rcnt_d  = 4'd0;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      target_q    <= 32'h0;
      rcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      rcnt_q      <= rcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ctrl_io.stall     = stall;
  assign ctrl_io.flush     = flush;
  assign ctrl_io.new_pc    = flush ? target_q : 32'h0;
  assign ctrl_io.busy      = (state_q != StIdle);
  assign ctrl_io.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level reference model checked every cycle,
// plus hand-computed checkpoints and a narrow-counter instance for saturation.
module tb_pipe_ctrl;

  localparam int unsigned Rc = 2;

  logic clk;
  logic rst;
  logic rst2;

  int vectors;
  int miscompares;

  pipe_ctrl_if #(.CNT_W(32)) bus ();
  pipe_ctrl_if #(.CNT_W(4))  bus2 ();

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .ERET_CODE  (32'h0000_000e),
    .RECOVER_CYC(Rc),
    .CNT_W      (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus.slave)
  );

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .ERET_CODE  (32'h0000_000e),
    .RECOVER_CYC(Rc),
    .CNT_W      (4)
  ) dut4 (
    .clk    (clk),
    .rst    (rst2),
    .ctrl_io(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] prio(input logic id, input logic ex, input logic mem);
    if (mem) return 6'b011111;
    if (ex)  return 6'b001111;
    if (id)  return 6'b000111;
    return 6'b000000;
  endfunction

  // Reference model: cycles left in the redirect sequence (freeze + flush + recovery).
  int          m_left;
  logic [31:0] m_tgt;
  longint      m_cnt;
  bit          m_valid;

  initial begin
    m_left  = 0;
    m_tgt   = 32'h0;
    m_cnt   = 0;
    m_valid = 0;
  end

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    int          k;
    e_flush = 1'b0;
    e_pc    = 32'h0;
    e_busy  = (m_left != 0);
    k       = int'(2 + Rc) - m_left;
    if (m_left == 0) begin
      e_stall = (bus.excepttype_i != 0) ? 6'b111111
              : prio(bus.stallreq_from_id, bus.stallreq_from_ex, bus.stallreq_from_mem);
    end else if (k == 0) begin
      e_stall = 6'b111111;
    end else if (k == 1) begin
      e_stall = 6'b000000;
      e_flush = 1'b1;
      e_pc    = m_tgt;
    end else begin
      e_stall = prio(bus.stallreq_from_id, bus.stallreq_from_ex, bus.stallreq_from_mem);
    end
    if (m_valid) begin
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("flush", 32'(bus.flush), 32'(e_flush));
      check("new_pc", bus.new_pc, e_pc);
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("stall_cnt", bus.stall_cnt, 32'(m_cnt));
    end
    // Advance the model with what the coming edge will see.
    if (rst) begin
      m_left  = 0;
      m_cnt   = 0;
      m_valid = 1;
    end else begin
      if (e_stall[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_left == 0 && bus.excepttype_i != 0) begin
        m_left = 2 + Rc;
        m_tgt  = (bus.excepttype_i == 32'h0000_000e) ? bus.cp0_epc_i : 32'h0000_0020;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stallreq_from_id  = 1'b0;
    bus.stallreq_from_ex  = 1'b0;
    bus.stallreq_from_mem = 1'b0;
    bus.excepttype_i      = 32'h0;
    bus.cp0_epc_i         = 32'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    idle_inputs();
    bus2.stallreq_from_id  = 1'b1;
    bus2.stallreq_from_ex  = 1'b0;
    bus2.stallreq_from_mem = 1'b0;
    bus2.excepttype_i      = 32'h0;
    bus2.cp0_epc_i         = 32'h0;
    step();
    rst  = 1'b0;
    rst2 = 1'b0;

    // Idle after reset.
    repeat (5) step();
    @(negedge clk);
    check("idle stall_cnt", bus.stall_cnt, 32'd0);
    check("idle stall", 32'(bus.stall), 32'h0);
    step();

    // ID request for three cycles, then ID+EX for one.
    bus.stallreq_from_id = 1'b1;
    @(negedge clk);
    check("id stall", 32'(bus.stall), 32'h07);
    step();
    step();
    step();
    bus.stallreq_from_ex = 1'b1;
    @(negedge clk);
    check("id+ex stall", 32'(bus.stall), 32'h0f);
    step();
    idle_inputs();
    @(negedge clk);
    check("cnt after id/ex", bus.stall_cnt, 32'd4);
    step();

    // Exception with a simultaneous MEM request.
    bus.excepttype_i      = 32'h1;
    bus.stallreq_from_mem = 1'b1;
    @(negedge clk);
    check("exc N stall", 32'(bus.stall), 32'h3f);
    step();
    bus.excepttype_i = 32'h0;
    @(negedge clk);
    check("exc N+1 stall", 32'(bus.stall), 32'h3f);
    step();
    @(negedge clk);
    check("exc flush", 32'(bus.flush), 32'h1);
    check("exc new_pc", bus.new_pc, 32'h0000_0020);
    check("exc flush stall", 32'(bus.stall), 32'h0);
    step();
    step();
    @(negedge clk);
    check("exc N+4 busy", 32'(bus.busy), 32'h1);
    step();
    @(negedge clk);
    check("exc N+5 busy", 32'(bus.busy), 32'h0);
    step();
    idle_inputs();
    step();

    // ERET: target latched from EPC at the exception cycle.
    bus.excepttype_i = 32'h0000_000e;
    bus.cp0_epc_i    = 32'h8000_0104;
    step();
    bus.excepttype_i = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    step();
    @(negedge clk);
    check("eret flush", 32'(bus.flush), 32'h1);
    check("eret new_pc", bus.new_pc, 32'h8000_0104);
    repeat (4) step();

    // Exception during recovery is masked, then taken once back in idle.
    bus.excepttype_i = 32'h1;
    step();
    bus.excepttype_i = 32'h0;
    step();
    step();
    bus.excepttype_i = 32'h5;
    @(negedge clk);
    check("masked busy", 32'(bus.busy), 32'h1);
    check("masked stall", 32'(bus.stall), 32'h0);
    step();
    step();
    @(negedge clk);
    check("retake stall", 32'(bus.stall), 32'h3f);
    check("retake busy", 32'(bus.busy), 32'h0);
    step();
    bus.excepttype_i = 32'h0;
    @(negedge clk);
    check("retake freeze busy", 32'(bus.busy), 32'h1);
    repeat (4) step();

    // Reset during freeze aborts the sequence.
    bus.excepttype_i = 32'h1;
    step();
    bus.excepttype_i = 32'h0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst abort flush", 32'(bus.flush), 32'h0);
    check("rst abort busy", 32'(bus.busy), 32'h0);
    check("rst abort cnt", bus.stall_cnt, 32'd0);
    repeat (4) step();

    // Narrow counter saturates and holds.
    @(negedge clk);
    check("cnt4 saturated", 32'(bus2.stall_cnt), 32'hf);
    repeat (5) step();
    @(negedge clk);
    check("cnt4 holds", 32'(bus2.stall_cnt), 32'hf);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control block for the 5-stage MIPS core.
- Merges stall requests from the ID, EX and MEM stages into the per-stage stall vector consumed by the PC register and the pipeline registers.
- Sequences exception/ERET redirection as freeze -> flush -> recovery, supplying the redirect PC.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect address for every non-ERET exception.
- ERET_CODE, 32'h0000000e, excepttype_i value meaning ERET (redirect to cp0_epc_i).
- RECOVER_CYC, 2, cycles after flush during which new exceptions are masked (1..15).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stallreq_from_id  in  1  ID stage requests stall (load-use hazard).
- stallreq_from_ex  in  1  EX stage requests stall (multi-cycle op).
- stallreq_from_mem  in  1  MEM stage requests stall (data bus busy).
- excepttype_i  in  32  exception type from MEM stage; 0 = none.
- cp0_epc_i  in  32  EPC value from CP0.
- stall  out  6  stage stall vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = hold.
- flush  out  1  one-cycle pulse; clears all pipeline registers.
- new_pc  out  32  redirect target; valid only while flush = 1.
- busy  out  1  1 while state != IDLE.
- stall_cnt  out  CNT_W  count of cycles with stall[0] = 1, saturating.

Behaviour:
- Reset: on the rising clk edge with rst = 1, state = IDLE, the internal redirect-target register = 0, and the recovery counter = 0.
- Reset output values: stall = 6'b000000, flush = 0, new_pc = 0, busy = 0, stall_cnt = 0.
- Reset mid-sequence (FREEZE, FLUSH or RECOVER) aborts to IDLE; no flush pulse is issued afterwards.
- States: IDLE, FREEZE, FLUSH, RECOVER.
- IDLE, excepttype_i != 0: go to FREEZE.
  - Combinationally in the same cycle, stall = 6'b111111.
  - At that edge, latch the target: cp0_epc_i if excepttype_i == ERET_CODE, else EXC_VECTOR.
- IDLE, no exception: stall is combinational from the requests, in this priority order:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - none -> 6'b000000
- FREEZE: exactly 1 cycle; stall = 6'b111111; go to FLUSH.
- FLUSH: exactly 1 cycle.
  - flush = 1 and new_pc = latched target (registered output).
  - stall = 0 regardless of any requests.
  - Go to RECOVER with the counter loaded to RECOVER_CYC.
- RECOVER:
  - stall follows the request priority above.
  - excepttype_i is ignored.
  - The counter decrements each cycle; go to IDLE when it reaches 1.
  - RECOVER therefore lasts exactly RECOVER_CYC cycles.
- Request and exception inputs are ignored in FREEZE and FLUSH.
- new_pc = 0 whenever flush = 0.
- Exception latency: exception presented in cycle N -> freeze in N, N+1 -> flush in N+2 -> IDLE after cycle N+2+RECOVER_CYC.
- Simultaneous events:
  - An exception in IDLE overrides all stall requests.
  - Simultaneous stall requests resolve to the highest-priority pattern only.
- stall_cnt increments at each edge where stall[0] = 1 (including FREEZE cycles); it holds at all-ones and never wraps.
- busy = 1 in FREEZE, FLUSH and RECOVER.

Test Plan:
- Reset then idle 5 cycles, no requests -> stall = 000000, flush = 0, new_pc = 0, busy = 0, stall_cnt = 0 throughout.
- stallreq_from_id = 1 for 3 cycles, then id+ex together for 1 cycle -> stall = 000111 ×3, then 001111; stall_cnt = 4 afterwards.
- excepttype_i = 32'h00000001 at cycle N, together with stallreq_from_mem -> stall = 111111 at N and N+1; at N+2 flush = 1, new_pc = 32'h00000020, stall = 000000; busy drops after N+4 with RECOVER_CYC = 2.
- excepttype_i = 32'h0000000e with cp0_epc_i = 32'h8000_0104; change cp0_epc_i to 0 at N+1 -> flush cycle shows new_pc = 32'h8000_0104 (value latched at N).
- Second exception asserted during RECOVER, then held into IDLE -> ignored in RECOVER; a new FREEZE starts in the first IDLE cycle.
- rst = 1 during FREEZE -> next cycle IDLE, no flush pulse ever appears; stall_cnt = 0. Separately, force stall_cnt to all-ones with CNT_W = 4 and keep requests asserted -> counter holds at 4'hF.
